// File: rtl/axi_user_pkg.sv
// Shared definitions for the two-client AXI USER arbiter: default widths,
// FSM state encoding and client port indices.
package axi_user_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   localparam logic PORT_D = 1'b0;
   localparam logic PORT_I = 1'b1;

endpackage

// File: rtl/axi_user_arbiter_rr_arb2.sv
// Two-way request picker: round-robin against the last granted port,
// or fixed priority to port 0 when fixed_prio is set.
module rr_arb2
   import axi_user_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       fixed_prio,
   output logic       grant
);

   always_comb begin
      grant = PORT_D;
      if (req == 2'b11) begin
         grant = fixed_prio ? PORT_D : ~last;
      end else if (req[1]) begin
         grant = PORT_I;
      end
   end

endmodule

// File: rtl/axi_user_arbiter.sv
// Shares one AXI USER master port between the D-cache (port 0) and I-cache
// (port 1); each client keeps its private start/busy/done protocol.
module axi_user_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LEN_W      = 8,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s0_start,
   input  logic              s0_rw,
   input  logic [ADDR_W-1:0] s0_addr,
   input  logic [LEN_W-1:0]  s0_len,
   input  logic [DATA_W-1:0] s0_wdata,
   input  logic              s0_wvalid,
   output logic              s0_wready,
   output logic [DATA_W-1:0] s0_rdata,
   output logic              s0_rvalid,
   output logic              s0_done,
   output logic              s0_busy,
   input  logic              s1_start,
   input  logic              s1_rw,
   input  logic [ADDR_W-1:0] s1_addr,
   input  logic [LEN_W-1:0]  s1_len,
   input  logic [DATA_W-1:0] s1_wdata,
   input  logic              s1_wvalid,
   output logic              s1_wready,
   output logic [DATA_W-1:0] s1_rdata,
   output logic              s1_rvalid,
   output logic              s1_done,
   output logic              s1_busy,
   output logic              m_start,
   output logic              m_rw,
   output logic [ADDR_W-1:0] m_addr,
   output logic [LEN_W-1:0]  m_len,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_wvalid,
   input  logic              m_wready,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_rvalid,
   input  logic              m_done,
   input  logic              m_busy
);

   import axi_user_pkg::*;

   typedef struct packed {
      logic              valid;
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
   } req_t;

   req_t [1:0]        pend_q, pend_d;
   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic              m_start_q, m_start_d;
   logic              m_rw_q, m_rw_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [LEN_W-1:0]  m_len_q, m_len_d;
   logic              winner;
   logic              xfer, own0, own1;

   assign xfer = (state_q == ST_XFER);
   assign own0 = xfer && (owner_q == PORT_D);
   assign own1 = xfer && (owner_q == PORT_I);

   rr_arb2 u_arb (
      .req        ({pend_q[1].valid, pend_q[0].valid}),
      .last       (last_grant_q),
      .fixed_prio (FIXED_PRIO != 0),
      .grant      (winner)
   );

   assign s0_busy   = pend_q[0].valid | own0;
   assign s1_busy   = pend_q[1].valid | own1;
   assign s0_rvalid = m_rvalid & own0;
   assign s1_rvalid = m_rvalid & own1;
   assign s0_wready = m_wready & own0;
   assign s1_wready = m_wready & own1;
   assign s0_done   = m_done & own0;
   assign s1_done   = m_done & own1;
   assign s0_rdata  = m_rdata;
   assign s1_rdata  = m_rdata;

   assign m_wdata  = own0 ? s0_wdata  : (own1 ? s1_wdata  : '0);
   assign m_wvalid = own0 ? s0_wvalid : (own1 ? s1_wvalid : 1'b0);

   assign m_start = m_start_q;
   assign m_rw    = m_rw_q;
   assign m_addr  = m_addr_q;
   assign m_len   = m_len_q;

   // A start captured this cycle is only arbitrated from the registered copy next cycle.
   always_comb begin
      pend_d       = pend_q;
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      m_start_d    = 1'b0;
      m_rw_d       = m_rw_q;
      m_addr_d     = m_addr_q;
      m_len_d      = m_len_q;

      if (s0_start && !s0_busy) pend_d[0] = {1'b1, s0_rw, s0_addr, s0_len};
      if (s1_start && !s1_busy) pend_d[1] = {1'b1, s1_rw, s1_addr, s1_len};

      case (state_q)
         ST_IDLE: begin
            if ((pend_q[0].valid || pend_q[1].valid) && !m_busy) begin
               owner_d               = winner;
               m_start_d             = 1'b1;
               m_rw_d                = pend_q[winner].rw;
               m_addr_d              = pend_q[winner].addr;
               m_len_d               = pend_q[winner].len;
               pend_d[winner].valid  = 1'b0;
               state_d               = ST_XFER;
            end
         end
         ST_XFER: begin
            if (m_done) begin
               state_d      = ST_IDLE;
               last_grant_d = owner_q;
               owner_d      = PORT_D;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q       <= '0;
         state_q      <= ST_IDLE;
         owner_q      <= PORT_D;
         last_grant_q <= PORT_I;
         m_start_q    <= 1'b0;
         m_rw_q       <= 1'b0;
         m_addr_q     <= '0;
         m_len_q      <= LEN_W'(1);
      end else begin
         pend_q       <= pend_d;
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         m_start_q    <= m_start_d;
         m_rw_q       <= m_rw_d;
         m_addr_q     <= m_addr_d;
         m_len_q      <= m_len_d;
      end
   end

   // Clients must never pulse start while their own busy is still high.
   a_s0_start_idle: assert property (@(posedge clk) disable iff (reset) !(s0_start && s0_busy));
   a_s1_start_idle: assert property (@(posedge clk) disable iff (reset) !(s1_start && s1_busy));

endmodule

// File: tb/tb_axi_user_arbiter.sv
// Self-checking bench for axi_user_arbiter: a round-robin and a fixed-priority
// instance share stimulus; grants are checked against a scoreboard queue.
module tb_axi_user_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        s0_start, s0_rw, s0_wvalid, s1_start, s1_rw, s1_wvalid;
   logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
   logic [7:0]  s0_len, s1_len;
   logic        m_wready, m_rvalid, m_done, m_busy;
   logic [31:0] m_rdata;

   logic        s0_wready, s0_rvalid, s0_done, s0_busy;
   logic        s1_wready, s1_rvalid, s1_done, s1_busy;
   logic [31:0] s0_rdata, s1_rdata, m_addr, m_wdata;
   logic        m_start, m_rw, m_wvalid;
   logic [7:0]  m_len;

   logic        fp_s0_wready, fp_s0_rvalid, fp_s0_done, fp_s0_busy;
   logic        fp_s1_wready, fp_s1_rvalid, fp_s1_done, fp_s1_busy;
   logic [31:0] fp_s0_rdata, fp_s1_rdata, fp_m_addr, fp_m_wdata;
   logic        fp_m_start, fp_m_rw, fp_m_wvalid;
   logic [7:0]  fp_m_len;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rw;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [31:0] fp_addr;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        s0_wvalid;
      logic        m_wready;
      logic        m_rvalid;
      logic [31:0] m_rdata;
      logic        e_m_wvalid;
      logic        e_s0_wready;
      logic        e_s1_wready;
      logic        e_s0_rvalid;
      logic        e_s1_rvalid;
   } vec_t;
   vec_t vecs[6];

   always #5 clk = ~clk;

   axi_user_arbiter dut (
      .clk(clk), .reset(reset),
      .s0_start(s0_start), .s0_rw(s0_rw), .s0_addr(s0_addr), .s0_len(s0_len),
      .s0_wdata(s0_wdata), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
      .s0_rdata(s0_rdata), .s0_rvalid(s0_rvalid), .s0_done(s0_done), .s0_busy(s0_busy),
      .s1_start(s1_start), .s1_rw(s1_rw), .s1_addr(s1_addr), .s1_len(s1_len),
      .s1_wdata(s1_wdata), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
      .s1_rdata(s1_rdata), .s1_rvalid(s1_rvalid), .s1_done(s1_done), .s1_busy(s1_busy),
      .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr), .m_len(m_len),
      .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_rdata(m_rdata),
      .m_rvalid(m_rvalid), .m_done(m_done), .m_busy(m_busy)
   );

   axi_user_arbiter #(.FIXED_PRIO(1)) dut_fp (
      .clk(clk), .reset(reset),
      .s0_start(s0_start), .s0_rw(s0_rw), .s0_addr(s0_addr), .s0_len(s0_len),
      .s0_wdata(s0_wdata), .s0_wvalid(s0_wvalid), .s0_wready(fp_s0_wready),
      .s0_rdata(fp_s0_rdata), .s0_rvalid(fp_s0_rvalid), .s0_done(fp_s0_done), .s0_busy(fp_s0_busy),
      .s1_start(s1_start), .s1_rw(s1_rw), .s1_addr(s1_addr), .s1_len(s1_len),
      .s1_wdata(s1_wdata), .s1_wvalid(s1_wvalid), .s1_wready(fp_s1_wready),
      .s1_rdata(fp_s1_rdata), .s1_rvalid(fp_s1_rvalid), .s1_done(fp_s1_done), .s1_busy(fp_s1_busy),
      .m_start(fp_m_start), .m_rw(fp_m_rw), .m_addr(fp_m_addr), .m_len(fp_m_len),
      .m_wdata(fp_m_wdata), .m_wvalid(fp_m_wvalid), .m_wready(m_wready), .m_rdata(m_rdata),
      .m_rvalid(m_rvalid), .m_done(m_done), .m_busy(m_busy)
   );

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Steps until the RR instance pulses m_start, then pops the scoreboard.
   task automatic applyStimulus_grant(input int exp_lat);
      int   cnt;
      exp_t e;
      cnt = 0;
      do begin
         step();
         s0_start = 1'b0;
         s1_start = 1'b0;
         cnt++;
      end while (!m_start && cnt < 20);
      checkOutput("grant_seen", 64'(m_start), 64'd1);
      checkOutput("grant_latency", 64'(cnt), 64'(exp_lat));
      checkOutput("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checkOutput("m_rw", 64'(m_rw), 64'(e.rw));
         checkOutput("m_addr", 64'(m_addr), 64'(e.addr));
         checkOutput("m_len", 64'(m_len), 64'(e.len));
         checkOutput("fp_m_addr", 64'(fp_m_addr), 64'(e.fp_addr));
      end
      step();
      checkOutput("m_start_pulse", 64'(m_start), 64'd0);
   endtask

   task automatic applyStimulus_beats(input int port, input int n, input logic [31:0] base,
                                      input logic with_done);
      for (int i = 0; i < n; i++) begin
         m_rvalid = 1'b1;
         m_rdata  = base + 32'(i);
         m_done   = with_done && (i == n - 1);
         #1;
         checkOutput("own_rvalid", 64'(port == 0 ? s0_rvalid : s1_rvalid), 64'd1);
         checkOutput("other_rvalid", 64'(port == 0 ? s1_rvalid : s0_rvalid), 64'd0);
         checkOutput("rdata", 64'(port == 0 ? s0_rdata : s1_rdata), 64'(base + 32'(i)));
         if (with_done && i == n - 1) begin
            checkOutput("own_done", 64'(port == 0 ? s0_done : s1_done), 64'd1);
            checkOutput("other_done", 64'(port == 0 ? s1_done : s0_done), 64'd0);
         end
         step();
      end
      m_rvalid = 1'b0;
      m_done   = 1'b0;
      #1;
      if (with_done) checkOutput("busy_after_done", 64'(port == 0 ? s0_busy : s1_busy), 64'd0);
   endtask

   task automatic applyStimulus_tie(input logic [31:0] a0, input logic [31:0] a1);
      s0_start = 1'b1; s0_rw = 1'b1; s0_addr = a0; s0_len = 8'd4;
      s1_start = 1'b1; s1_rw = 1'b1; s1_addr = a1; s1_len = 8'd4;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      reset = 1'b1;
      s0_start = 0; s0_rw = 0; s0_addr = 0; s0_len = 1; s0_wdata = 0; s0_wvalid = 0;
      s1_start = 0; s1_rw = 0; s1_addr = 0; s1_len = 1; s1_wdata = 0; s1_wvalid = 0;
      m_wready = 0; m_rdata = 0; m_rvalid = 0; m_done = 0; m_busy = 0;
      repeat (3) step();
      reset = 1'b0;
      step();

      $display("[TB] reset state and stray status in IDLE");
      checkOutput("rst_m_start", 64'(m_start), 64'd0);
      checkOutput("rst_m_rw", 64'(m_rw), 64'd0);
      checkOutput("rst_m_addr", 64'(m_addr), 64'd0);
      checkOutput("rst_m_len", 64'(m_len), 64'd1);
      checkOutput("rst_busy", 64'({s0_busy, s1_busy}), 64'd0);
      m_rvalid = 1; m_wready = 1; m_done = 1;
      #1;
      checkOutput("idle_stray", 64'({s0_rvalid, s1_rvalid, s0_wready, s1_wready, s0_done, s1_done}), 64'd0);
      m_rvalid = 0; m_wready = 0; m_done = 0;
      step();

      $display("[TB] simultaneous starts, first tie");
      applyStimulus_tie(32'h100, 32'h200);
      sb.push_back('{1'b1, 32'h100, 8'd4, 32'h100});
      sb.push_back('{1'b1, 32'h200, 8'd4, 32'h200});
      applyStimulus_grant(2);
      checkOutput("tie1_s1_busy_waiting", 64'(s1_busy), 64'd1);
      applyStimulus_beats(0, 4, 32'hB0, 1'b1);
      checkOutput("tie1_s1_still_busy", 64'(s1_busy), 64'd1);
      applyStimulus_grant(1);
      applyStimulus_beats(1, 4, 32'hC0, 1'b1);

      $display("[TB] single read on port 0");
      s0_start = 1; s0_rw = 1; s0_addr = 32'h1000_0040; s0_len = 8'd4;
      sb.push_back('{1'b1, 32'h1000_0040, 8'd4, 32'h1000_0040});
      #1;
      checkOutput("s0_busy_before_capture", 64'(s0_busy), 64'd0);
      applyStimulus_grant(2);
      applyStimulus_beats(0, 4, 32'hA0, 1'b1);

      $display("[TB] simultaneous starts, second tie");
      applyStimulus_tie(32'h100, 32'h200);
      sb.push_back('{1'b1, 32'h200, 8'd4, 32'h100});
      sb.push_back('{1'b1, 32'h100, 8'd4, 32'h200});
      applyStimulus_grant(2);
      applyStimulus_beats(1, 4, 32'hD0, 1'b1);
      applyStimulus_grant(1);
      applyStimulus_beats(0, 4, 32'hE0, 1'b1);

      $display("[TB] write pass-through on port 0");
      s0_start = 1; s0_rw = 0; s0_addr = 32'h80; s0_len = 8'd1;
      s0_wdata = 32'hDEADBEEF; s0_wvalid = 1;
      s1_wdata = 32'h12345678; s1_wvalid = 1;
      sb.push_back('{1'b0, 32'h80, 8'd1, 32'h80});
      step();
      s0_start = 0;
      #1;
      checkOutput("wdata_no_owner", 64'(m_wdata), 64'd0);
      checkOutput("wvalid_no_owner", 64'(m_wvalid), 64'd0);
      applyStimulus_grant(1);
      for (int i = 0; i < 6; i++) begin
         s0_wvalid = vecs[i].s0_wvalid;
         m_wready  = vecs[i].m_wready;
         m_rvalid  = vecs[i].m_rvalid;
         m_rdata   = vecs[i].m_rdata;
         #1;
         checkOutput($sformatf("vec%0d_m_wdata", i), 64'(m_wdata), 64'hDEADBEEF);
         checkOutput($sformatf("vec%0d_m_wvalid", i), 64'(m_wvalid), 64'(vecs[i].e_m_wvalid));
         checkOutput($sformatf("vec%0d_s0_wready", i), 64'(s0_wready), 64'(vecs[i].e_s0_wready));
         checkOutput($sformatf("vec%0d_s1_wready", i), 64'(s1_wready), 64'(vecs[i].e_s1_wready));
         checkOutput($sformatf("vec%0d_s0_rvalid", i), 64'(s0_rvalid), 64'(vecs[i].e_s0_rvalid));
         checkOutput($sformatf("vec%0d_s1_rvalid", i), 64'(s1_rvalid), 64'(vecs[i].e_s1_rvalid));
         step();
      end
      m_wready = 1; m_done = 1; m_rvalid = 0;
      #1;
      checkOutput("wr_s0_done", 64'(s0_done), 64'd1);
      step();
      m_wready = 0; m_done = 0; s0_wvalid = 0; s1_wvalid = 0;
      #1;
      checkOutput("wr_s0_busy_after", 64'(s0_busy), 64'd0);
      checkOutput("wr_wdata_after", 64'(m_wdata), 64'd0);

      $display("[TB] m_busy stall with port 1 pending");
      m_busy = 1;
      s1_start = 1; s1_rw = 1; s1_addr = 32'h4000; s1_len = 8'd2;
      sb.push_back('{1'b1, 32'h4000, 8'd2, 32'h4000});
      step();
      s1_start = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         checkOutput($sformatf("stall%0d_m_start", i), 64'(m_start), 64'd0);
      end
      checkOutput("stall_s1_busy", 64'(s1_busy), 64'd1);
      m_busy = 0;
      applyStimulus_grant(1);
      applyStimulus_beats(1, 2, 32'hF0, 1'b1);

      $display("[TB] reset in the middle of a burst");
      s0_start = 1; s0_rw = 1; s0_addr = 32'h9000; s0_len = 8'd4;
      sb.push_back('{1'b1, 32'h9000, 8'd4, 32'h9000});
      applyStimulus_grant(2);
      s1_start = 1; s1_rw = 1; s1_addr = 32'h9100; s1_len = 8'd4;
      step();
      s1_start = 0;
      #1;
      checkOutput("mid_s1_pending", 64'(s1_busy), 64'd1);
      applyStimulus_beats(0, 2, 32'h70, 1'b0);
      reset = 1;
      step();
      reset = 0;
      #1;
      checkOutput("mrst_m_start", 64'(m_start), 64'd0);
      checkOutput("mrst_m_addr", 64'(m_addr), 64'd0);
      checkOutput("mrst_m_len", 64'(m_len), 64'd1);
      checkOutput("mrst_busy", 64'({s0_busy, s1_busy}), 64'd0);
      m_done = 1; m_rvalid = 1;
      #1;
      checkOutput("mrst_stray", 64'({s0_done, s1_done, s0_rvalid, s1_rvalid}), 64'd0);
      step();
      m_done = 0; m_rvalid = 0;
      step();
      checkOutput("mrst_no_grant", 64'(m_start), 64'd0);
      checkOutput("sb_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
